// File: rtl/prefetch_pkg.sv
// Shared types for the prefetch issue path:
// line address type and arbiter state encoding.
package prefetch_pkg;

  localparam int ADDR_W  = 64;
  localparam int LOGLINE = 6;
  localparam int LINE_W  = ADDR_W - LOGLINE;

  typedef logic [LINE_W-1:0] line_addr_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/pf_request_queue.sv
// Prefetch candidate queue: circular buffer with per-entry
// valid bits, parallel line match and squash-by-line.
module pf_request_queue #(
  parameter int LW    = 58,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [LW-1:0]              push_line_i,
  input  logic                       pop_i,
  input  logic                       squash_i,
  input  logic [LW-1:0]              squash_line_i,
  input  logic [LW-1:0]              match_line_i,
  output logic [DEPTH-1:0]           match_vec_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic                       head_valid_o,
  output logic [LW-1:0]              head_line_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [LW-1:0]    line_q [DEPTH];
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  assign head_valid_o = ~empty_o & vld_q[head_q];
  assign head_line_o  = line_q[head_q];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      match_vec_o[i] = vld_q[i] & (line_q[i] == match_line_i);
    end
  end

  // Squash first, then pop, then push: a slot freed by pop is never
  // the tail unless the queue was empty, where nothing is popped.
  always_comb begin
    vld_d = vld_q;
    if (squash_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (line_q[i] == squash_line_i) vld_d[i] = 1'b0;
      end
    end
    if (pop_ok)  vld_d[head_q] = 1'b0;
    if (push_ok) vld_d[tail_q] = 1'b1;
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    cnt_d  = cnt_q;
    if (pop_ok)  head_d = head_q + 1'b1;
    if (push_ok) tail_d = tail_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        line_q[i] <= '0;
      end
    end else begin
      vld_q  <= vld_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      if (push_ok) line_q[tail_q] <= push_line_i;
    end
  end

endmodule

// File: rtl/prefetch_issue_arbiter.sv
// Shares the lower-level request port between demand misses and
// queued prefetches, with MSHR-based throttling.
module prefetch_issue_arbiter #(
  parameter int WIDTH          = 64,
  parameter int LOGLINE        = prefetch_pkg::LOGLINE,
  parameter int PQ_DEPTH       = 4,
  parameter int MSHR_COUNT     = 16,
  parameter int MSHR_THRESHOLD = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dem_valid_i,
  input  logic [WIDTH-1:0] dem_address_i,
  output logic             dem_ready_o,
  input  logic             pf_valid_i,
  input  logic [WIDTH-1:0] pf_address_i,
  output logic             pf_ready_o,
  output logic             lo_valid_o,
  output logic [WIDTH-1:0] lo_address_o,
  output logic             lo_is_prefetch_o,
  input  logic             lo_ready_i,
  input  logic             lo_done_i,
  output logic [15:0]      pf_drop_count_o
);

  import prefetch_pkg::*;

  localparam int LW = WIDTH - LOGLINE;
  localparam int OW = $clog2(MSHR_COUNT + 1);
  localparam int CW = $clog2(PQ_DEPTH + 1);

  arb_state_e     state_q, state_d;
  logic [LW-1:0]  lo_line_q, lo_line_d;
  logic           lo_pf_q, lo_pf_d;
  logic [OW-1:0]  out_q, out_d;
  logic [15:0]    drop_q, drop_d;

  logic [LW-1:0]       dem_line, pf_line, head_line;
  logic [PQ_DEPTH-1:0] q_match_vec;
  logic [CW-1:0]       q_count;
  logic q_empty, q_full, head_valid;
  logic idle, below_max, below_thr;
  logic dem_acc, pf_issue, pf_discard, pop;
  logic pf_dup, push, drop, hs, done_ok;
  logic unused_low;

  assign dem_line = dem_address_i[WIDTH-1:LOGLINE];
  assign pf_line  = pf_address_i[WIDTH-1:LOGLINE];
  assign unused_low = ^{dem_address_i[LOGLINE-1:0],
                        pf_address_i[LOGLINE-1:0]};

  assign idle      = (state_q == IDLE);
  assign below_max = (out_q < OW'(MSHR_COUNT));
  assign below_thr = (out_q < OW'(MSHR_THRESHOLD));

  assign dem_ready_o = idle & below_max;
  assign dem_acc     = dem_valid_i & dem_ready_o;
  assign pf_issue    = idle & ~dem_acc & head_valid & below_thr;
  assign pf_discard  = idle & ~dem_acc & ~q_empty & ~head_valid;
  assign pop         = pf_issue | pf_discard;

  // Duplicates are judged against pre-pop queue contents, the
  // in-flight output register and the demand on the wire this cycle.
  assign pf_dup = (|q_match_vec)
                | (~idle & (lo_line_q == pf_line))
                | (dem_valid_i & (dem_line == pf_line));
  assign push   = pf_valid_i & ~pf_dup & ~q_full;
  assign drop   = pf_valid_i & ~pf_dup & q_full;

  assign hs      = lo_valid_o & lo_ready_i;
  assign done_ok = lo_done_i & (out_q != '0);

  pf_request_queue #(
    .LW    (LW),
    .DEPTH (PQ_DEPTH)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .push_i        (push),
    .push_line_i   (pf_line),
    .pop_i         (pop),
    .squash_i      (dem_acc),
    .squash_line_i (dem_line),
    .match_line_i  (pf_line),
    .match_vec_o   (q_match_vec),
    .empty_o       (q_empty),
    .full_o        (q_full),
    .head_valid_o  (head_valid),
    .head_line_o   (head_line),
    .count_o       (q_count)
  );

  always_comb begin
    state_d   = state_q;
    lo_line_d = lo_line_q;
    lo_pf_d   = lo_pf_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          dem_acc: begin
            state_d   = BUSY;
            lo_line_d = dem_line;
            lo_pf_d   = 1'b0;
          end
          pf_issue: begin
            state_d   = BUSY;
            lo_line_d = head_line;
            lo_pf_d   = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      BUSY: begin
        if (lo_ready_i) state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    out_d = out_q;
    unique case ({hs, done_ok})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase
    drop_d = drop_q;
    if (drop && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      lo_line_q <= '0;
      lo_pf_q   <= 1'b0;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      lo_line_q <= lo_line_d;
      lo_pf_q   <= lo_pf_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  assign lo_valid_o       = (state_q == BUSY);
  assign lo_address_o     = {lo_line_q, {LOGLINE{1'b0}}};
  assign lo_is_prefetch_o = lo_pf_q;
  assign pf_ready_o       = (q_count < CW'(PQ_DEPTH));
  assign pf_drop_count_o  = drop_q;

endmodule

// File: tb/tb_prefetch_issue_arbiter.sv
// Self-checking bench for prefetch_issue_arbiter: vector table
// plus scoreboard of expected lower-level requests.
module tb_prefetch_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dem_valid_i = 1'b0;
  logic [63:0] dem_address_i = '0;
  logic        dem_ready_o;
  logic        pf_valid_i = 1'b0;
  logic [63:0] pf_address_i = '0;
  logic        pf_ready_o;
  logic        lo_valid_o;
  logic [63:0] lo_address_o;
  logic        lo_is_prefetch_o;
  logic        lo_ready_i = 1'b0;
  logic        lo_done_i = 1'b0;
  logic [15:0] pf_drop_count_o;

  always #5 clk = ~clk;

  prefetch_issue_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .dem_valid_i      (dem_valid_i),
    .dem_address_i    (dem_address_i),
    .dem_ready_o      (dem_ready_o),
    .pf_valid_i       (pf_valid_i),
    .pf_address_i     (pf_address_i),
    .pf_ready_o       (pf_ready_o),
    .lo_valid_o       (lo_valid_o),
    .lo_address_o     (lo_address_o),
    .lo_is_prefetch_o (lo_is_prefetch_o),
    .lo_ready_i       (lo_ready_i),
    .lo_done_i        (lo_done_i),
    .pf_drop_count_o  (pf_drop_count_o)
  );

  typedef struct {
    logic [63:0] addr;
    logic        pf;
  } exp_t;

  typedef struct {
    logic        is_dem;
    logic [63:0] addr;
    logic [63:0] exp_addr;
    logic        exp_pf;
    int          exp_lat;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl[6];
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst && lo_valid_o && lo_ready_i) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL lo_unexpected: got addr %h pf %b, required none",
                 lo_address_o, lo_is_prefetch_o);
      end else begin
        mon_e = sb.pop_front();
        chk("lo_addr", lo_address_o, mon_e.addr);
        chk("lo_is_pf", lo_is_prefetch_o, mon_e.pf);
      end
    end
  end

  task automatic drive_dem(input logic [63:0] a);
    int n = 0;
    sb.push_back(exp_t'{addr: a & ~64'h3F, pf: 1'b0});
    dem_valid_i   = 1'b1;
    dem_address_i = a;
    do begin
      @(negedge clk);
      n++;
    end while (!dem_ready_o && n < 40);
    n_cmp++;
    if (!dem_ready_o) begin
      n_fail++;
      $display("FAIL dem_accept_timeout: dem_ready_o=%b required 1",
               dem_ready_o);
    end
    @(posedge clk);
    #1;
    dem_valid_i = 1'b0;
  endtask

  task automatic pf_pulse(input logic [63:0] a);
    pf_valid_i   = 1'b1;
    pf_address_i = a;
    @(posedge clk);
    #1;
    pf_valid_i = 1'b0;
  endtask

  task automatic pulse_done(input int n);
    for (int i = 0; i < n; i++) begin
      lo_done_i = 1'b1;
      @(posedge clk);
      #1;
      lo_done_i = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    chk("sb_drained", 64'(sb.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    tbl[0] = '{1'b1, 64'h1040, 64'h1040, 1'b0, 1};
    tbl[1] = '{1'b1, 64'h107F, 64'h1040, 1'b0, 1};
    tbl[2] = '{1'b0, 64'h2000, 64'h2000, 1'b1, 2};
    tbl[3] = '{1'b0, 64'h2FFF, 64'h2FC0, 1'b1, 2};
    tbl[4] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFC0, 1'b0, 1};
    tbl[5] = '{1'b0, 64'h0, 64'h0, 1'b1, 2};

    // Reset with lo_done_i pulsing throughout.
    lo_done_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_lo_valid", lo_valid_o, 0);
    chk("rst_lo_addr", lo_address_o, 0);
    chk("rst_lo_pf", lo_is_prefetch_o, 0);
    chk("rst_drop", pf_drop_count_o, 0);
    chk("rst_dem_ready", dem_ready_o, 1);
    chk("rst_pf_ready", pf_ready_o, 1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    lo_done_i = 1'b0;
    @(negedge clk);
    chk("no_underflow_dem_ready", dem_ready_o, 1);
    chk("post_rst_pf_ready", pf_ready_o, 1);
    @(posedge clk);
    #1;

    // Single requests from an idle, empty block.
    lo_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      sb.push_back(exp_t'{addr: tbl[i].exp_addr, pf: tbl[i].exp_pf});
      if (tbl[i].is_dem) begin
        dem_valid_i   = 1'b1;
        dem_address_i = tbl[i].addr;
      end else begin
        pf_valid_i   = 1'b1;
        pf_address_i = tbl[i].addr;
      end
      @(posedge clk);
      #1;
      dem_valid_i = 1'b0;
      pf_valid_i  = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!lo_valid_o && lat < 8);
      chk("row_latency", lat, tbl[i].exp_lat);
      @(posedge clk);
      #1;
      pulse_done(1);
    end
    wait_drain();

    // Demand and prefetch together: demand wins, prefetch 2 later.
    sb.push_back(exp_t'{addr: 64'h1040, pf: 1'b0});
    sb.push_back(exp_t'{addr: 64'h2000, pf: 1'b1});
    dem_valid_i   = 1'b1;
    dem_address_i = 64'h1040;
    pf_valid_i    = 1'b1;
    pf_address_i  = 64'h2000;
    @(posedge clk);
    #1;
    dem_valid_i = 1'b0;
    pf_valid_i  = 1'b0;
    @(negedge clk);
    chk("prio_dem_valid", lo_valid_o, 1);
    chk("prio_dem_pf", lo_is_prefetch_o, 0);
    @(negedge clk);
    chk("prio_gap", lo_valid_o, 0);
    @(negedge clk);
    chk("prio_pf_valid", lo_valid_o, 1);
    chk("prio_pf_pf", lo_is_prefetch_o, 1);
    @(posedge clk);
    #1;
    wait_drain();
    pulse_done(2);

    // Duplicate prefetch lines are discarded silently.
    lo_ready_i = 1'b0;
    pf_pulse(64'h100);
    pf_pulse(64'h100);
    pf_pulse(64'h140);
    @(negedge clk);
    chk("dup_drop_count", pf_drop_count_o, 0);
    chk("dup_hold_addr", lo_address_o, 64'h100);
    sb.push_back(exp_t'{addr: 64'h100, pf: 1'b1});
    sb.push_back(exp_t'{addr: 64'h140, pf: 1'b1});
    lo_ready_i = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);
    chk("dup_no_extra", lo_valid_o, 0);
    @(posedge clk);
    #1;
    pulse_done(2);

    // Full queue drops; full plus pop still drops.
    lo_ready_i = 1'b0;
    drive_dem(64'h5000);
    pf_pulse(64'h400);
    pf_pulse(64'h440);
    pf_pulse(64'h480);
    pf_pulse(64'h4C0);
    @(negedge clk);
    chk("full_pf_ready", pf_ready_o, 0);
    @(posedge clk);
    #1;
    pf_pulse(64'h500);
    @(negedge clk);
    chk("full_drop1", pf_drop_count_o, 1);
    chk("full_pf_ready_after_drop", pf_ready_o, 0);
    sb.push_back(exp_t'{addr: 64'h400, pf: 1'b1});
    sb.push_back(exp_t'{addr: 64'h440, pf: 1'b1});
    sb.push_back(exp_t'{addr: 64'h480, pf: 1'b1});
    sb.push_back(exp_t'{addr: 64'h4C0, pf: 1'b1});
    lo_ready_i = 1'b1;
    @(posedge clk);
    #1;
    pf_valid_i   = 1'b1;
    pf_address_i = 64'h600;
    @(posedge clk);
    #1;
    pf_valid_i = 1'b0;
    @(negedge clk);
    chk("full_pop_drop2", pf_drop_count_o, 2);
    chk("pf_ready_after_pop", pf_ready_o, 1);
    wait_drain();
    pulse_done(5);

    // Demand squashes a queued prefetch of the same line.
    lo_ready_i = 1'b0;
    drive_dem(64'h7000);
    pf_pulse(64'h300);
    lo_ready_i = 1'b1;
    drive_dem(64'h300);
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("squash_no_issue", lo_valid_o, 0);
    end
    @(posedge clk);
    #1;
    pulse_done(2);

    // MSHR throttling: prefetches stop at 12, demands at 16.
    for (int i = 0; i < 12; i++) begin
      drive_dem(64'h10000 + 64'(i) * 64);
    end
    wait_drain();
    pf_pulse(64'h900);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("pf_throttled", lo_valid_o, 0);
    end
    @(posedge clk);
    #1;
    for (int i = 12; i < 16; i++) begin
      drive_dem(64'h10000 + 64'(i) * 64);
    end
    wait_drain();
    @(negedge clk);
    chk("dem_ready_at_max", dem_ready_o, 0);
    @(posedge clk);
    #1;
    lo_done_i = 1'b1;
    @(negedge clk);
    chk("dem_ready_same_cycle", dem_ready_o, 0);
    @(posedge clk);
    #1;
    lo_done_i = 1'b0;
    @(negedge clk);
    chk("dem_ready_after_done", dem_ready_o, 1);
    @(posedge clk);
    #1;
    pulse_done(3);
    @(negedge clk);
    chk("pf_held_at_threshold", lo_valid_o, 0);
    @(posedge clk);
    #1;
    sb.push_back(exp_t'{addr: 64'h900, pf: 1'b1});
    pulse_done(1);
    wait_drain();
    pulse_done(12);

    // Reset mid-transaction loses the pending request.
    lo_ready_i = 1'b0;
    drive_dem(64'hB000);
    pf_pulse(64'hB040);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_lo_valid", lo_valid_o, 0);
    chk("midrst_dem_ready", dem_ready_o, 1);
    chk("midrst_pf_ready", pf_ready_o, 1);
    chk("midrst_drop", pf_drop_count_o, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    lo_ready_i = 1'b1;
    repeat (6) @(negedge clk);
    chk("midrst_no_replay", lo_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
